// File: rtl/sm_clk_sequencer.sv
// sm_clk_sequencer
// Turns the fast board clock into a CPU clock-enable pulse train. Four run
// modes are supported (stop, continuous run, debounced single step and a
// fixed-length burst), and every delivered pulse is counted for debug.

module sm_clk_sequencer #(
   parameter int SHIFT    = 16,
   parameter int DEBOUNCE = 16
) (
   input  logic        clkIn,
   input  logic        rst_n,
   input  logic [1:0]  mode,
   input  logic [3:0]  devide,
   input  logic        stepBtn,
   input  logic        start,
   input  logic [7:0]  burstLen,
   output logic        cpuEn,
   output logic        busy,
   output logic [7:0]  burstLeft,
   output logic [31:0] tickCount
);

   localparam logic [1:0] MODE_STOP  = 2'd0;
   localparam logic [1:0] MODE_RUN   = 2'd1;
   localparam logic [1:0] MODE_STEP  = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2,
      STEP  = 2'd3
   } state_t;

   state_t                stateQ;
   logic                  cpuEnQ;
   logic                  busyQ;
   logic [7:0]            burstLeftQ;
   logic [31:0]           tickCountQ;
   logic [30:0]           prescalerQ;

   logic [1:0]            syncQ;
   logic [DEBOUNCE-1:0]   debCntQ;
   logic                  acceptedQ;
   logic                  acceptedPrevQ;
   logic                  startPrevQ;

   logic [4:0]            pExp;
   logic [30:0]           tickMask;
   logic                  tick;
   logic                  synced;
   logic                  stepReq;
   logic                  startRise;

   // Prescale exponent and the low-bit mask whose all-ones pattern marks a tick.
   // With an exponent of zero the mask is empty, so every edge ticks.
   always_comb begin
      pExp     = 5'(SHIFT) + {1'b0, devide};
      tickMask = 31'((32'd1 << pExp) - 32'd1);
      tick     = ((prescalerQ & tickMask) == tickMask);
      synced   = syncQ[1];
      stepReq  = acceptedQ & ~acceptedPrevQ;
      startRise = start & ~startPrevQ;
   end

   // Button synchronizer, debounce filter and the edge-detect history for
   // both the accepted button level and the burst start input.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         syncQ         <= 2'b00;
         debCntQ       <= '0;
         acceptedQ     <= 1'b0;
         acceptedPrevQ <= 1'b0;
         startPrevQ    <= 1'b0;
      end else begin
         syncQ         <= {syncQ[0], stepBtn};
         acceptedPrevQ <= acceptedQ;
         startPrevQ    <= start;
         if (synced != acceptedQ) begin
            if (debCntQ == '1) begin
               acceptedQ <= ~acceptedQ;
               debCntQ   <= '0;
            end else begin
               debCntQ <= debCntQ + 1'b1;
            end
         end else begin
            debCntQ <= '0;
         end
      end
   end

   // Run-control FSM: owns the prescaler, the pulse output, the burst
   // countdown and the delivered-pulse counter. A mode change out of RUN or
   // BURST always drops back to IDLE without emitting a pulse that edge.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         stateQ     <= IDLE;
         cpuEnQ     <= 1'b0;
         busyQ      <= 1'b0;
         burstLeftQ <= 8'd0;
         tickCountQ <= 32'd0;
         prescalerQ <= 31'd0;
      end else begin
         cpuEnQ <= 1'b0;
         case (stateQ)
            IDLE: begin
               prescalerQ <= 31'd0;
               if (mode == MODE_RUN) begin
                  stateQ <= RUN;
                  busyQ  <= 1'b1;
               end else if ((mode == MODE_BURST) && startRise && (burstLen != 8'd0)) begin
                  stateQ     <= BURST;
                  busyQ      <= 1'b1;
                  burstLeftQ <= burstLen;
               end else if ((mode == MODE_STEP) && stepReq) begin
                  stateQ     <= STEP;
                  busyQ      <= 1'b1;
                  cpuEnQ     <= 1'b1;
                  tickCountQ <= tickCountQ + 32'd1;
               end else begin
                  busyQ <= 1'b0;
               end
            end

            RUN: begin
               if (mode != MODE_RUN) begin
                  stateQ     <= IDLE;
                  busyQ      <= 1'b0;
                  prescalerQ <= 31'd0;
               end else if (tick) begin
                  cpuEnQ     <= 1'b1;
                  tickCountQ <= tickCountQ + 32'd1;
                  prescalerQ <= 31'd0;
               end else begin
                  prescalerQ <= prescalerQ + 31'd1;
               end
            end

            BURST: begin
               if (mode != MODE_BURST) begin
                  stateQ     <= IDLE;
                  busyQ      <= 1'b0;
                  burstLeftQ <= 8'd0;
                  prescalerQ <= 31'd0;
               end else if (tick) begin
                  cpuEnQ     <= 1'b1;
                  tickCountQ <= tickCountQ + 32'd1;
                  burstLeftQ <= burstLeftQ - 8'd1;
                  prescalerQ <= 31'd0;
                  if (burstLeftQ == 8'd1) begin
                     stateQ <= IDLE;
                     busyQ  <= 1'b0;
                  end
               end else begin
                  prescalerQ <= prescalerQ + 31'd1;
               end
            end

            STEP: begin
               stateQ <= IDLE;
               busyQ  <= 1'b0;
            end

            default: begin
               stateQ <= IDLE;
               busyQ  <= 1'b0;
            end
         endcase
      end
   end

   assign cpuEn     = cpuEnQ;
   assign busy      = busyQ;
   assign burstLeft = burstLeftQ;
   assign tickCount = tickCountQ;

   // MODE_STOP needs no explicit branch; it is simply "not the current mode".
   logic unusedStop;
   assign unusedStop = (mode == MODE_STOP);

endmodule

// File: tb/tb_sm_clk_sequencer.sv
// Testbench for sm_clk_sequencer (SHIFT=1, DEBOUNCE=2). Expected pulse edges
// are pushed to a queue as stimulus is applied; a negedge monitor pops and
// compares each time cpuEn is seen high.

module tb_sm_clk_sequencer;

   logic        clkIn = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic [3:0]  devide;
   logic        stepBtn;
   logic        start;
   logic [7:0]  burstLen;
   logic        cpuEn;
   logic        busy;
   logic [7:0]  burstLeft;
   logic [31:0] tickCount;

   int          edgeNum = 0;
   int          assertCount = 0;
   int          failCount = 0;
   int          expQ[$];
   int          e;

   sm_clk_sequencer #(
      .SHIFT    (1),
      .DEBOUNCE (2)
   ) dut (
      .clkIn     (clkIn),
      .rst_n     (rst_n),
      .mode      (mode),
      .devide    (devide),
      .stepBtn   (stepBtn),
      .start     (start),
      .burstLen  (burstLen),
      .cpuEn     (cpuEn),
      .busy      (busy),
      .burstLeft (burstLeft),
      .tickCount (tickCount)
   );

   // Free-running board clock.
   always #5 clkIn = ~clkIn;

   // Number of rising edges seen so far; at a negedge it names the last edge.
   always @(posedge clkIn) edgeNum = edgeNum + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [3:0] d,
                                input logic s, input logic [7:0] bl);
      mode     = m;
      devide   = d;
      start    = s;
      burstLen = bl;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clkIn);
   endtask

   // Scoreboard monitor: every cpuEn pulse must match the oldest expected edge.
   always @(negedge clkIn) begin
      if (rst_n === 1'b1 && cpuEn === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedPulse", 32'(edgeNum), 32'hFFFF_FFFF);
         end else begin
            checkOutput("pulseEdge", 32'(edgeNum), 32'(expQ.pop_front()));
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      stepBtn = 1'b0;
      applyStimulus(2'd0, 4'd0, 1'b0, 8'd0);
      waitCycles(3);
      checkOutput("rstCpuEn", 32'(cpuEn), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstBurstLeft", 32'(burstLeft), 32'd0);
      checkOutput("rstTickCount", tickCount, 32'd0);
      rst_n = 1'b1;
      waitCycles(2);

      $display("[TB] continuous run, P=2");
      applyStimulus(2'd1, 4'd1, 1'b0, 8'd0);
      e = edgeNum + 1;
      expQ.push_back(e + 4); expQ.push_back(e + 8);
      expQ.push_back(e + 12); expQ.push_back(e + 16);
      waitCycles(1);
      checkOutput("runBusyEntry", 32'(busy), 32'd1);
      waitCycles(17);
      checkOutput("runTickCount", tickCount, 32'd4);
      checkOutput("runBusyHeld", 32'(busy), 32'd1);
      checkOutput("runQueueEmpty", 32'(expQ.size()), 32'd0);
      mode = 2'd0;
      waitCycles(2);
      checkOutput("runStopBusy", 32'(busy), 32'd0);

      $display("[TB] devide change 2 -> 0 mid run");
      applyStimulus(2'd1, 4'd2, 1'b0, 8'd0);
      e = edgeNum + 1;
      expQ.push_back(e + 8); expQ.push_back(e + 16);
      waitCycles(17);
      devide = 4'd0;
      expQ.push_back(e + 18); expQ.push_back(e + 20); expQ.push_back(e + 22);
      waitCycles(6);
      mode = 2'd0;
      waitCycles(3);
      checkOutput("devTickCount", tickCount, 32'd9);
      checkOutput("devQueueEmpty", 32'(expQ.size()), 32'd0);

      $display("[TB] burst of 3 with a second start edge");
      applyStimulus(2'd3, 4'd1, 1'b0, 8'd3);
      waitCycles(2);
      checkOutput("burstWaitBusy", 32'(busy), 32'd0);
      start = 1'b1;
      e = edgeNum + 1;
      expQ.push_back(e + 4); expQ.push_back(e + 8); expQ.push_back(e + 12);
      waitCycles(1);
      checkOutput("burstLeft3", 32'(burstLeft), 32'd3);
      checkOutput("burstBusy", 32'(busy), 32'd1);
      start = 1'b0;
      waitCycles(3);
      start = 1'b1;
      waitCycles(2);
      checkOutput("burstLeft2", 32'(burstLeft), 32'd2);
      start = 1'b0;
      waitCycles(4);
      checkOutput("burstLeft1", 32'(burstLeft), 32'd1);
      checkOutput("burstBusyMid", 32'(busy), 32'd1);
      waitCycles(3);
      checkOutput("burstLastCpuEn", 32'(cpuEn), 32'd1);
      checkOutput("burstLastBusy", 32'(busy), 32'd0);
      checkOutput("burstLeft0", 32'(burstLeft), 32'd0);
      waitCycles(6);
      checkOutput("burstTickCount", tickCount, 32'd12);
      checkOutput("burstQueueEmpty", 32'(expQ.size()), 32'd0);

      $display("[TB] burst of 5 aborted after two pulses");
      burstLen = 8'd5;
      start    = 1'b1;
      e = edgeNum + 1;
      expQ.push_back(e + 4); expQ.push_back(e + 8);
      waitCycles(9);
      checkOutput("abortLeft3", 32'(burstLeft), 32'd3);
      mode  = 2'd0;
      start = 1'b0;
      waitCycles(1);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortLeft0", 32'(burstLeft), 32'd0);
      waitCycles(10);
      checkOutput("abortTickCount", tickCount, 32'd14);

      $display("[TB] zero-length burst");
      applyStimulus(2'd3, 4'd1, 1'b0, 8'd0);
      waitCycles(2);
      start = 1'b1;
      waitCycles(3);
      checkOutput("zeroLenBusy", 32'(busy), 32'd0);
      checkOutput("zeroLenLeft", 32'(burstLeft), 32'd0);
      checkOutput("zeroLenTickCount", tickCount, 32'd14);
      applyStimulus(2'd0, 4'd1, 1'b0, 8'd0);
      waitCycles(2);

      $display("[TB] single step with debounce");
      mode = 2'd2;
      waitCycles(2);
      stepBtn = 1'b1;
      e = edgeNum + 1;
      expQ.push_back(e + 6);
      waitCycles(7);
      checkOutput("stepCpuEn", 32'(cpuEn), 32'd1);
      checkOutput("stepBusy", 32'(busy), 32'd1);
      waitCycles(12);
      checkOutput("stepHeldTickCount", tickCount, 32'd15);
      checkOutput("stepIdleBusy", 32'(busy), 32'd0);
      stepBtn = 1'b0;
      waitCycles(10);
      for (int g = 0; g < 2; g++) begin
         stepBtn = 1'b1;
         waitCycles(2);
         stepBtn = 1'b0;
         waitCycles(10);
      end
      checkOutput("glitchTickCount", tickCount, 32'd15);
      checkOutput("stepQueueEmpty", 32'(expQ.size()), 32'd0);
      mode = 2'd0;
      waitCycles(2);

      $display("[TB] reset during run");
      applyStimulus(2'd1, 4'd1, 1'b0, 8'd0);
      e = edgeNum + 1;
      expQ.push_back(e + 4);
      waitCycles(7);
      checkOutput("preResetTickCount", tickCount, 32'd16);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRstCpuEn", 32'(cpuEn), 32'd0);
      checkOutput("asyncRstBusy", 32'(busy), 32'd0);
      checkOutput("asyncRstTickCount", tickCount, 32'd0);
      waitCycles(2);
      rst_n = 1'b1;
      e = edgeNum + 1;
      expQ.push_back(e + 4); expQ.push_back(e + 8);
      waitCycles(1);
      checkOutput("reentryBusy", 32'(busy), 32'd1);
      waitCycles(8);
      checkOutput("reentryTickCount", tickCount, 32'd2);
      mode = 2'd0;
      waitCycles(3);
      checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/sm_clk_sequencer.md
# sm_clk_sequencer

Run-control sequencer that generates the CPU clock-enable pulse train from the fast board clock. It sits between the input metastability filters and the core. It replaces free-running divided-clock stepping with four selectable modes: stop, continuous run, single step from a debounced push button, and a fixed-length burst. It also counts delivered pulses for debug readout.

## Interface
- SHIFT, 16: base prescale exponent; tick period is 2^(SHIFT+devide) clkIn cycles; SHIFT+15 ≤ 31 required.
- DEBOUNCE, 16: step button must be stable for 2^DEBOUNCE consecutive cycles to be accepted.

Ports (one clock; reset is asynchronous and active-low):
- clkIn  in  1  sole clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  0 STOP, 1 RUN, 2 STEP, 3 BURST; synchronous, sampled every edge.
- devide  in  4  prescale extension, P = SHIFT+devide; synchronous.
- stepBtn  in  1  raw asynchronous push button, active high.
- start  in  1  synchronous; rising edge launches a burst.
- burstLen  in  8  pulses per burst; sampled on launch.
- cpuEn  out  1  registered one-cycle clock-enable pulse to the CPU.
- busy  out  1  registered, high when FSM not IDLE.
- burstLeft  out  8  pulses remaining in current burst.
- tickCount  out  32  total cpuEn pulses since reset, wraps modulo 2^32.

## Operation
- Reset (async, immediate): state IDLE; cpuEn, busy, burstLeft, tickCount, prescaler, debounce counter, accepted button level, startPrev all 0.
- Prescaler: 31-bit counter, cleared on entry to RUN/BURST, increments each edge in RUN/BURST. Tick when prescaler[P-1:0] are all ones; on tick, prescaler clears. A devide change mid-period takes effect at the next all-ones match.
- Button path: 2-flop synchronizer. Debounce counter increments while synced ≠ accepted and clears otherwise. When it is at 2^DEBOUNCE−1 and still differs, accepted toggles and the counter clears. stepReq = accepted rising edge (registered previous accepted).
- startRise = start & ~startPrev; startPrev registered every edge.
- FSM states IDLE, RUN, BURST, STEP:
  - IDLE, mode=RUN → RUN.
  - IDLE, mode=BURST & startRise & burstLen≠0 → BURST, burstLeft←burstLen.
  - IDLE, mode=STEP & stepReq → STEP, cpuEn←1.
  - Otherwise stay. stepReq/startRise that do not cause a transition are discarded, never queued.
  - RUN: on tick, cpuEn←1. If mode≠RUN at an edge → IDLE with no pulse that edge, even if tick.
  - BURST: on tick, cpuEn←1, burstLeft−1. On the tick with burstLeft=1, go to IDLE at that same edge. If mode≠BURST → IDLE, burstLeft←0, no pulse. startRise ignored while in BURST.
  - STEP: unconditional → IDLE next edge (cpuEn falls).
- cpuEn is high for exactly one cycle per pulse and never high on two consecutive cycles except when P=0.
- tickCount increments on every edge at which cpuEn is set to 1.
- Direct RUN↔BURST mode switch passes through IDLE; BURST then requires a fresh startRise.

## Timing
- RUN/BURST entry at edge E: pulses after edges E+2^P, E+2·2^P, …
- Burst: busy falls at the same edge the last cpuEn rises. busy and cpuEn overlap for one cycle except for the final pulse.
- Step latency: edge 0 is the first edge sampling stepBtn high. accepted=1 after edge 2^DEBOUNCE+1, and cpuEn is high in the cycle after edge 2^DEBOUNCE+2.
- A button glitch shorter than 2^DEBOUNCE synced cycles produces no pulse.
- Mid-operation reset drops cpuEn/busy asynchronously. Operation resumes from IDLE; a mode still at RUN re-enters RUN at the first edge after reset release.

## Test plan
- SHIFT=1, devide=1 (P=2), mode=RUN for 20 cycles → cpuEn pulses after edges 5, 9, 13, 17 (entry edge 1); tickCount=4; busy=1 throughout.
- P=2, mode=BURST, burstLen=3, start 0→1 at edge 10 → pulses after edges 14, 18, 22; busy falls after edge 22; burstLeft 3→2→1→0; a second start edge mid-burst is ignored.
- DEBOUNCE=2, mode=STEP, stepBtn high from edge 0 → single cpuEn after edge 6, tickCount=1. Holding the button gives no further pulse; 2-cycle glitches give none.
- P=2, mode=BURST, burstLen=5, switch mode to STOP after second pulse → IDLE next edge, burstLeft=0, no further pulses, tickCount=2.
- RUN with rst_n pulsed low mid-period → cpuEn, busy, tickCount immediately 0; after release, first pulse 2^P edges after RUN re-entry.
- burstLen=0 with start edge → stays IDLE, busy=0; devide change 2→0 mid-RUN (SHIFT=1) → period shrinks from 8 to 2 cycles at the next low-bit all-ones match.
